param_wb_cache: RTL and testbench

- Parametrised direct-mapped, write-back, write-allocate cache between the CPU datapath and a line-wide memory port.
- Adds per-line valid bits, separate read/write data buses, and a variable-latency memory handshake using mem_ready.
- Coexists with the DMA controller: a new miss sequence never starts while BG is high, and hits are still served during DMA.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/param_wb_cache_if.sv | 50 +++++
 rtl/cache_line_array.sv | 76 +++++++
 rtl/param_wb_cache.sv | 173 +++++++++++++++++
 tb/tb_param_wb_cache.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the param_wb_cache slice:
//   - cache_state_t : controller states IDLE / WB / FILL
//   - DEF_*         : default parameter values for the cache and its interface
//   - STAT_WIDTH    : width of the optional statistics counters
//   - tag_bits()    : address-split helper giving the tag width from the
//                     address width, line count and words per line
// -----------------------------------------------------------------------------
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } cache_state_t;

  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_WORD_WIDTH     = 16;
  localparam int DEF_NUM_LINES      = 4;
  localparam int DEF_WORDS_PER_LINE = 4;

  localparam int STAT_WIDTH = 16;

  // Word address layout is {tag, index, offset}; the tag takes what is left.
  function automatic int tag_bits(input int addr_width, input int num_lines,
                                  input int words_per_line);
    return addr_width - $clog2(num_lines) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/param_wb_cache_if.sv
// -----------------------------------------------------------------------------
// param_wb_cache_if
// Bundles the CPU-side request bus, the line-wide memory port and the DMA
// arbitration pair of the write-back cache.
//   CPU side : cpu_read, cpu_write, cpu_addr, cpu_wdata -> cache
//              cpu_rdata, stall                         <- cache
//   Memory   : mem_addr, mem_read, mem_write, mem_wdata <- cache
//              mem_rdata, mem_ready                     -> cache
//   Arbiter  : BG -> cache, accessing_memory <- cache
// Modports: slave = the cache, master = the environment around it.
// -----------------------------------------------------------------------------
interface param_wb_cache_if
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
);
  localparam int LINE_WIDTH = WORD_WIDTH * WORDS_PER_LINE;

  logic                  cpu_read;
  logic                  cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [WORD_WIDTH-1:0] cpu_wdata;
  logic [WORD_WIDTH-1:0] cpu_rdata;
  logic                  stall;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read;
  logic                  mem_write;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  logic                  BG;
  logic                  accessing_memory;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready, BG,
    output cpu_rdata, stall, mem_addr, mem_read, mem_write, mem_wdata,
           accessing_memory
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready, BG,
    input  cpu_rdata, stall, mem_addr, mem_read, mem_write, mem_wdata,
           accessing_memory
  );

endinterface

// File: rtl/cache_line_array.sv
// -----------------------------------------------------------------------------
// cache_line_array
// Tag / valid / dirty / data storage for a direct-mapped cache.
//   index, offset          : line and word selected this cycle
//   rd_word, rd_line       : combinational read of the selected word / line
//   rd_tag, rd_valid,
//   rd_dirty               : combinational read of the selected line's state
//   word_we, word_wdata    : posedge write of one word; marks the line dirty
//   fill_we, fill_line,
//   fill_tag               : posedge write of a whole line; valid=1, dirty=0
//   clean_we               : posedge clear of the selected line's dirty bit
// Valid and dirty bits clear asynchronously on reset_n; tags and data do not.
// -----------------------------------------------------------------------------
module cache_line_array #(
  parameter  int NUM_LINES      = 4,
  parameter  int WORDS_PER_LINE = 4,
  parameter  int WORD_WIDTH     = 16,
  parameter  int TAG_BITS       = 12,
  localparam int INDEX_BITS     = $clog2(NUM_LINES),
  localparam int OFFSET_BITS    = $clog2(WORDS_PER_LINE),
  localparam int LINE_WIDTH     = WORD_WIDTH * WORDS_PER_LINE
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [INDEX_BITS-1:0]  index,
  input  logic [OFFSET_BITS-1:0] offset,
  output logic [WORD_WIDTH-1:0]  rd_word,
  output logic [LINE_WIDTH-1:0]  rd_line,
  output logic [TAG_BITS-1:0]    rd_tag,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  input  logic                   word_we,
  input  logic [WORD_WIDTH-1:0]  word_wdata,
  input  logic                   fill_we,
  input  logic [LINE_WIDTH-1:0]  fill_line,
  input  logic [TAG_BITS-1:0]    fill_tag,
  input  logic                   clean_we
);

  logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] data_q [NUM_LINES];
  logic [TAG_BITS-1:0]                       tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0]                      valid_q;
  logic [NUM_LINES-1:0]                      dirty_q;

  assign rd_line  = data_q[index];
  assign rd_word  = data_q[index][offset];
  assign rd_tag   = tag_q[index];
  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];

  // NOTE: tag and data arrays carry no reset -- a line is meaningless until
  // its valid bit is set, and leaving them unreset lets them map onto RAM.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[index] <= fill_line;
      tag_q[index]  <= fill_tag;
    end else if (word_we) begin
      data_q[index][offset] <= word_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end else if (clean_we) begin
      dirty_q[index] <= 1'b0;
    end
  end

endmodule

// File: rtl/param_wb_cache.sv
// -----------------------------------------------------------------------------
// param_wb_cache
// Direct-mapped, write-back, write-allocate cache between the CPU and a
// line-wide memory port, sharing that port with a DMA controller.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : param_wb_cache_if.slave (CPU bus, memory port, BG /
//                  accessing_memory arbitration pair)
//   access_count, miss_count : saturating statistics, present only when
//                  CACHE_STATS_EN is defined
// Hits complete with zero added latency. A miss (never started while BG=1)
// writes back a dirty victim (WB), then fetches the line (FILL); the held CPU
// request then re-evaluates as a hit, so write misses merge through the
// normal write-hit path.
// -----------------------------------------------------------------------------
module param_wb_cache
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  param_wb_cache_if.slave       bus
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] access_count,
  output logic [STAT_WIDTH-1:0] miss_count
`endif
);

  localparam int INDEX_BITS  = $clog2(NUM_LINES);
  localparam int OFFSET_BITS = $clog2(WORDS_PER_LINE);
  localparam int TAG_BITS    = tag_bits(ADDR_WIDTH, NUM_LINES, WORDS_PER_LINE);
  localparam int LINE_WIDTH  = WORD_WIDTH * WORDS_PER_LINE;

  logic [TAG_BITS-1:0]    tag;
  logic [INDEX_BITS-1:0]  index;
  logic [OFFSET_BITS-1:0] offset;

  assign tag    = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign index  = bus.cpu_addr[OFFSET_BITS +: INDEX_BITS];
  assign offset = bus.cpu_addr[OFFSET_BITS-1:0];

  cache_state_t          state;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [LINE_WIDTH-1:0] mem_wdata_q;

  logic [WORD_WIDTH-1:0] rd_word;
  logic [LINE_WIDTH-1:0] rd_line;
  logic [TAG_BITS-1:0]   rd_tag;
  logic                  rd_valid;
  logic                  rd_dirty;

  logic request;
  logic write_only;
  logic hit;
  logic in_idle;
  logic miss_go;
  logic stall;

  assign request    = bus.cpu_read | bus.cpu_write;
  // A simultaneous read and write is served as a read.
  assign write_only = bus.cpu_write & ~bus.cpu_read;
  assign hit        = rd_valid && (rd_tag == tag);
  assign in_idle    = (state == IDLE);
  // New miss sequences wait while the DMA owns the memory bus.
  assign miss_go    = in_idle && request && !hit && !bus.BG;

  cache_line_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .WORD_WIDTH     (WORD_WIDTH),
    .TAG_BITS       (TAG_BITS)
  ) u_lines (
    .clk        (clk),
    .reset_n    (reset_n),
    .index      (index),
    .offset     (offset),
    .rd_word    (rd_word),
    .rd_line    (rd_line),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .word_we    (in_idle && write_only && hit),
    .word_wdata (bus.cpu_wdata),
    .fill_we    ((state == FILL) && bus.mem_ready),
    .fill_line  (bus.mem_rdata),
    .fill_tag   (tag),
    .clean_we   ((state == WB) && bus.mem_ready)
  );

  // stall and accessing_memory are forced low while reset is held so the
  // outputs read zero immediately, even with a request still asserted.
  assign stall                = reset_n && request && !(in_idle && hit);
  assign bus.stall            = stall;
  assign bus.accessing_memory = reset_n && (!in_idle || (request && !hit));
  assign bus.cpu_rdata        = (in_idle && bus.cpu_read && hit) ? rd_word : '0;

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every right-hand side sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_go) begin
            if (rd_valid && rd_dirty) begin
              state       <= WB;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {rd_tag, index, {OFFSET_BITS{1'b0}}};
              mem_wdata_q <= rd_line;
            end else begin
              state      <= FILL;
              mem_read_q <= 1'b1;
              mem_addr_q <= {tag, index, {OFFSET_BITS{1'b0}}};
            end
          end
        end
        WB: begin
          if (bus.mem_ready) begin
            state       <= FILL;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= {tag, index, {OFFSET_BITS{1'b0}}};
          end
        end
        FILL: begin
          if (bus.mem_ready) begin
            state      <= IDLE;
            mem_read_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      access_count <= '0;
      miss_count   <= '0;
    end else begin
      if (request && !stall && (access_count != '1)) begin
        access_count <= access_count + 1'b1;
      end
      if (miss_go && (miss_count != '1)) begin
        miss_count <= miss_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_param_wb_cache.sv
// -----------------------------------------------------------------------------
// tb_param_wb_cache
// Directed bench for param_wb_cache. A behavioural cache model (arrays of
// lines addressed with plain arithmetic) predicts the outputs; a compare
// process checks them on every falling edge, and the stimulus sequence adds
// hand-computed literal expectations. A memory responder answers mem_read /
// mem_write after mem_lat cycles from a line-addressed associative store.
// -----------------------------------------------------------------------------
module tb_param_wb_cache;

  localparam int AW  = 16;
  localparam int WW  = 16;
  localparam int NL  = 4;
  localparam int WPL = 4;
  localparam int LW  = WW * WPL;

  logic clk;
  logic reset_n;

  param_wb_cache_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WORDS_PER_LINE(WPL)) bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] access_count;
  logic [15:0] miss_count;
`endif

  param_wb_cache #(
    .ADDR_WIDTH     (AW),
    .WORD_WIDTH     (WW),
    .NUM_LINES      (NL),
    .WORDS_PER_LINE (WPL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef CACHE_STATS_EN
    ,
    .access_count (access_count),
    .miss_count   (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory store and responder ----------------
  logic [LW-1:0] mem_lines [int];
  int mem_lat  = 3;
  int wait_cnt = 0;

  // Unwritten lines read back as their own word addresses.
  function automatic logic [LW-1:0] mem_get(input int base);
    if (mem_lines.exists(base)) return mem_lines[base];
    return {16'(base + 3), 16'(base + 2), 16'(base + 1), 16'(base)};
  endfunction

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        wait_cnt = 0;
      end else if (bus.mem_read || bus.mem_write) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          bus.mem_ready = 1'b1;
          wait_cnt = 0;
          if (bus.mem_write) mem_lines[int'(bus.mem_addr)] = bus.mem_wdata;
          else bus.mem_rdata = mem_get(int'(bus.mem_addr));
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- behavioural cache model ----------------
  bit          m_valid [NL];
  bit          m_dirty [NL];
  int          m_tag   [NL];
  logic [WW-1:0] m_word [NL][WPL];
  int          m_phase = 0;   // 0 serving CPU, 1 writing victim back, 2 fetching line
  int          m_wb_addr = 0;
  logic [LW-1:0] m_wb_line = '0;
  int          m_acc = 0;
  int          m_miss = 0;

  function automatic int f_idx(input int a);  return (a / WPL) % NL; endfunction
  function automatic int f_off(input int a);  return a % WPL;        endfunction
  function automatic int f_tag(input int a);  return a / (WPL * NL); endfunction
  function automatic int f_base(input int a); return a - (a % WPL);  endfunction

  function automatic bit m_hit(input int a);
    return m_valid[f_idx(a)] && (m_tag[f_idx(a)] == f_tag(a));
  endfunction

  function automatic logic [LW-1:0] m_line(input int i);
    logic [LW-1:0] l;
    for (int w = 0; w < WPL; w++) l[w*WW +: WW] = m_word[i][w];
    return l;
  endfunction

  initial begin
    int a;
    int i;
    bit h;
    bit rq;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int k = 0; k < NL; k++) begin
          m_valid[k] = 1'b0;
          m_dirty[k] = 1'b0;
        end
        m_phase = 0;
        m_acc   = 0;
        m_miss  = 0;
      end else begin
        a  = int'(bus.cpu_addr);
        i  = f_idx(a);
        h  = m_hit(a);
        rq = bus.cpu_read || bus.cpu_write;
        case (m_phase)
          0: begin
            if (rq && h && m_acc < 65535) m_acc++;
            if (rq && !h && !bus.BG) begin
              if (m_miss < 65535) m_miss++;
              if (m_valid[i] && m_dirty[i]) begin
                m_phase   = 1;
                m_wb_addr = (m_tag[i] * NL + i) * WPL;
                m_wb_line = m_line(i);
              end else begin
                m_phase = 2;
              end
            end else if (bus.cpu_write && !bus.cpu_read && h) begin
              m_word[i][f_off(a)] = bus.cpu_wdata;
              m_dirty[i] = 1'b1;
            end
          end
          1: if (bus.mem_ready) begin
            m_dirty[i] = 1'b0;
            m_phase = 2;
          end
          default: if (bus.mem_ready) begin
            for (int w = 0; w < WPL; w++) m_word[i][w] = bus.mem_rdata[w*WW +: WW];
            m_tag[i]   = f_tag(a);
            m_valid[i] = 1'b1;
            m_dirty[i] = 1'b0;
            m_phase    = 0;
          end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    int  a;
    bit  rq;
    bit  e_stall;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        if (!reset_n) begin
          check("cmp.rst_stall", bus.stall, 0);
          check("cmp.rst_acc", bus.accessing_memory, 0);
          check("cmp.rst_mem_read", bus.mem_read, 0);
          check("cmp.rst_mem_write", bus.mem_write, 0);
          check("cmp.rst_mem_addr", bus.mem_addr, 0);
          check("cmp.rst_rdata", bus.cpu_rdata, 0);
        end else begin
          a  = int'(bus.cpu_addr);
          rq = bus.cpu_read || bus.cpu_write;
          e_stall = rq && !(m_phase == 0 && m_hit(a));
          check("cmp.stall", bus.stall, e_stall);
          check("cmp.acc", bus.accessing_memory, (m_phase != 0) || (rq && !m_hit(a)));
          check("cmp.mem_read", bus.mem_read, m_phase == 2);
          check("cmp.mem_write", bus.mem_write, m_phase == 1);
          if (m_phase == 1) begin
            check("cmp.wb_addr", bus.mem_addr, m_wb_addr);
            check("cmp.wb_data", bus.mem_wdata, m_wb_line);
          end
          if (m_phase == 2) check("cmp.fill_addr", bus.mem_addr, f_base(a));
          if (bus.cpu_read && !e_stall)
            check("cmp.rdata", bus.cpu_rdata, m_word[f_idx(a)][f_off(a)]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit rd, input bit wr, input logic [AW-1:0] a,
                     input logic [WW-1:0] d);
    bus.cpu_read  = rd;
    bus.cpu_write = wr;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  // Leaves the bench on the falling edge where stall has dropped.
  task automatic wait_ready(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (bus.stall && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.stall, 0);
  endtask

  task automatic wait_mem_read(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (!bus.mem_read && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.mem_read, 1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within 50000 time units");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    bus.BG  = 1'b0;
    req(0, 0, '0, '0);
    mem_lines[16'h0010] = 64'h4444_3333_2222_1111;
    mem_lines[16'h0110] = 64'h8888_7777_6666_5555;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.stall", bus.stall, 0);
    check("rst.acc", bus.accessing_memory, 0);
    check("rst.mem_read", bus.mem_read, 0);
    check("rst.mem_write", bus.mem_write, 0);
    check("rst.mem_addr", bus.mem_addr, 0);
    check("rst.mem_wdata", bus.mem_wdata, 0);
    check("rst.rdata", bus.cpu_rdata, 0);
    tick();
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Clean read miss on 0x0012, fill after 3 memory cycles.
    req(1, 0, 16'h0012, '0);
    @(negedge clk);
    check("miss1.stall", bus.stall, 1);
    check("miss1.acc", bus.accessing_memory, 1);
    check("miss1.mem_read", bus.mem_read, 0);
    @(negedge clk);
    check("fill1.mem_read", bus.mem_read, 1);
    check("fill1.mem_addr", bus.mem_addr, 16'h0010);
    wait_ready("fill1.done", 20);
    check("fill1.rdata", bus.cpu_rdata, 16'h3333);

    // Write hit, then read back.
    tick();
    req(0, 1, 16'h0011, 16'hBEEF);
    @(negedge clk);
    check("whit.stall", bus.stall, 0);
    check("whit.mem_read", bus.mem_read, 0);
    check("whit.mem_write", bus.mem_write, 0);
    check("whit.acc", bus.accessing_memory, 0);
    tick();
    req(1, 0, 16'h0011, '0);
    @(negedge clk);
    check("rhit.stall", bus.stall, 0);
    check("rhit.rdata", bus.cpu_rdata, 16'hBEEF);

    // Conflict miss on dirty line 0: writeback then fill.
    tick();
    req(1, 0, 16'h0112, '0);
    @(negedge clk);
    check("evict.stall", bus.stall, 1);
    @(negedge clk);
    check("wb.mem_write", bus.mem_write, 1);
    check("wb.mem_addr", bus.mem_addr, 16'h0010);
    check("wb.mem_wdata", bus.mem_wdata, 64'h4444_3333_BEEF_1111);
    wait_mem_read("wb2fill", 20);
    check("fill2.mem_addr", bus.mem_addr, 16'h0110);
    check("fill2.mem_write", bus.mem_write, 0);
    wait_ready("fill2.done", 20);
    check("fill2.rdata", bus.cpu_rdata, 16'h7777);

    // DMA owns the bus: hits still served, misses wait.
    tick();
    bus.BG = 1'b1;
    req(1, 0, 16'h0111, '0);
    @(negedge clk);
    check("bg_hit.stall", bus.stall, 0);
    check("bg_hit.rdata", bus.cpu_rdata, 16'h6666);
    tick();
    req(1, 0, 16'h0024, '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bg_miss.stall", bus.stall, 1);
      check("bg_miss.mem_read", bus.mem_read, 0);
      check("bg_miss.mem_write", bus.mem_write, 0);
    end
    tick();
    bus.BG = 1'b0;
    @(negedge clk);
    check("bg_drop.mem_read", bus.mem_read, 0);
    @(negedge clk);
    check("bg_fill.mem_read", bus.mem_read, 1);
    check("bg_fill.mem_addr", bus.mem_addr, 16'h0024);
    wait_ready("bg_fill.done", 20);
    check("bg_fill.rdata", bus.cpu_rdata, 16'h0024);

    // Reset in the middle of a fill.
    tick();
    req(1, 0, 16'h0038, '0);
    @(negedge clk);
    @(negedge clk);
    check("rstf.in_fill", bus.mem_read, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstf.stall", bus.stall, 0);
    check("rstf.mem_read", bus.mem_read, 0);
    check("rstf.mem_addr", bus.mem_addr, 0);
    check("rstf.mem_wdata", bus.mem_wdata, 0);
    check("rstf.acc", bus.accessing_memory, 0);
    check("rstf.rdata", bus.cpu_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    req(1, 0, 16'h0024, '0);
    @(negedge clk);
    check("post.stall", bus.stall, 1);
    wait_ready("post.done", 20);
    check("post.rdata", bus.cpu_rdata, 16'h0024);

    tick();
    req(0, 0, '0, '0);
    repeat (2) tick();

`ifdef CACHE_STATS_EN
    check("stats.access", access_count, m_acc);
    check("stats.miss", miss_count, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
